// File: rtl/devtbl_walker.sv
// devtbl_walker: PI1 initiator that reads the SoC version and walks the device
// table (id/size word pairs), builds an indexed table of id/base/size/irq and
// afterwards issues devtbl reset commands on behalf of a controller.
module devtbl_walker #(
    parameter int unsigned ARCHBITSZ    = 32,
    parameter int unsigned DEVTBLADDR   = 'h0080,
    parameter int unsigned FIRSTDEVADDR = 0,
    parameter int unsigned MAXDEVS      = 16,
    localparam int unsigned BSEL        = $clog2(ARCHBITSZ/8),
    localparam int unsigned ADDRBITSZ   = ARCHBITSZ - BSEL,
    localparam int unsigned IDXW        = $clog2(MAXDEVS),
    localparam int unsigned CNTW        = IDXW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [1:0]             pi1_op_o,
    output logic [ADDRBITSZ-1:0]   pi1_addr_o,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
    input  logic                   pi1_rdy_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ARCHBITSZ-1:0]   version_o,
    output logic [CNTW-1:0]        devcnt_o,
    input  logic [IDXW-1:0]        idx_i,
    output logic [ARCHBITSZ-1:0]   ent_id_o,
    output logic [ADDRBITSZ-1:0]   ent_base_o,
    output logic [ADDRBITSZ-1:0]   ent_sz_o,
    output logic                   ent_irq_o,
    input  logic                   cmd_vld_i,
    input  logic [1:0]             cmd_i,
    output logic                   cmd_ack_o
);

    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_RW   = 2'b11;

    localparam logic [ADDRBITSZ-1:0] TBL_ADDR   = ADDRBITSZ'(DEVTBLADDR);
    localparam logic [ADDRBITSZ-1:0] FIRST_BASE = ADDRBITSZ'(FIRSTDEVADDR);
    localparam logic [CNTW-1:0]      LAST_K     = CNTW'(MAXDEVS - 1);

    typedef enum logic [3:0] {
        ST_VERREQ,
        ST_VERRSP,
        ST_IDREQ,
        ST_IDRSP,
        ST_SZREQ,
        ST_SZRSP,
        ST_DONE,
        ST_CMDREQ,
        ST_CMDRSP
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [ADDRBITSZ-1:0]   addr_q, addr_d;
    logic [ARCHBITSZ-1:0]   data_q, data_d;
    logic [ARCHBITSZ-1:0]   version_q, version_d;
    logic [CNTW-1:0]        k_q, k_d;
    logic [ADDRBITSZ-1:0]   base_q, base_d;
    logic [ARCHBITSZ-1:0]   id_q, id_d;
    logic [1:0]             cmd_q, cmd_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   wr_en;

    // Entry storage; validity is implied by index < k_q, so no reset needed.
    logic [ARCHBITSZ-1:0]   id_mem   [MAXDEVS];
    logic [ADDRBITSZ-1:0]   base_mem [MAXDEVS];
    logic [ADDRBITSZ-1:0]   sz_mem   [MAXDEVS];
    logic                   irq_mem  [MAXDEVS];

    logic [ARCHBITSZ-1:0]   ent_id_q;
    logic [ADDRBITSZ-1:0]   ent_base_q;
    logic [ADDRBITSZ-1:0]   ent_sz_q;
    logic                   ent_irq_q;

    // Size word is a byte count; its word count drops the byte-offset bits.
    logic [ADDRBITSZ-1:0]   rsp_sz;
    logic [ADDRBITSZ-1:0]   id_addr;
    logic [IDXW-1:0]        wr_idx;
    logic                   lk_hit;

    assign rsp_sz  = pi1_data_i[ARCHBITSZ-1:BSEL];
    assign id_addr = TBL_ADDR + (ADDRBITSZ'(k_q) << 1);
    assign wr_idx  = k_q[IDXW-1:0];
    assign lk_hit  = ({1'b0, idx_i} < k_q);

    // State and bus-output registers; all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_VERREQ;
            op_q      <= OP_NOOP;
            addr_q    <= '0;
            data_q    <= '0;
            version_q <= '0;
            k_q       <= '0;
            base_q    <= FIRST_BASE;
            id_q      <= '0;
            cmd_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            version_q <= version_d;
            k_q       <= k_d;
            base_q    <= base_d;
            id_q      <= id_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic: a REQ state first loads its op, then drops to NOOP
    // once the op is accepted; the matching RSP state waits for rdy to sample.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        version_d = version_q;
        k_d       = k_q;
        base_d    = base_q;
        id_d      = id_q;
        cmd_d     = cmd_q;
        done_d    = done_q;
        ack_d     = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            ST_VERREQ: begin
                if (op_q == OP_NOOP) begin
                    op_d   = OP_RW;
                    addr_d = TBL_ADDR;
                    data_d = '0;
                end else if (pi1_rdy_i) begin
                    op_d    = OP_NOOP;
                    state_d = ST_VERRSP;
                end
            end
            ST_VERRSP: begin
                if (pi1_rdy_i) begin
                    version_d = pi1_data_i;
                    state_d   = ST_IDREQ;
                end
            end
            ST_IDREQ: begin
                if (op_q == OP_NOOP) begin
                    op_d   = OP_RD;
                    addr_d = id_addr;
                    data_d = '0;
                end else if (pi1_rdy_i) begin
                    op_d    = OP_NOOP;
                    state_d = ST_IDRSP;
                end
            end
            ST_IDRSP: begin
                if (pi1_rdy_i) begin
                    if (pi1_data_i == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        id_d    = pi1_data_i;
                        state_d = ST_SZREQ;
                    end
                end
            end
            ST_SZREQ: begin
                if (op_q == OP_NOOP) begin
                    op_d   = OP_RD;
                    addr_d = id_addr + 1'b1;
                    data_d = '0;
                end else if (pi1_rdy_i) begin
                    op_d    = OP_NOOP;
                    state_d = ST_SZRSP;
                end
            end
            ST_SZRSP: begin
                if (pi1_rdy_i) begin
                    wr_en  = 1'b1;
                    base_d = base_q + rsp_sz;
                    k_d    = k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDREQ;
                    end
                end
            end
            ST_DONE: begin
                // Skip the cycle right after an ack so a still-held request
                // is not taken a second time.
                if (cmd_vld_i && !ack_q) begin
                    cmd_d   = cmd_i;
                    state_d = ST_CMDREQ;
                end
            end
            ST_CMDREQ: begin
                if (op_q == OP_NOOP) begin
                    op_d   = OP_RW;
                    addr_d = TBL_ADDR + 1'b1;
                    data_d = ARCHBITSZ'(cmd_q);
                end else if (pi1_rdy_i) begin
                    op_d    = OP_NOOP;
                    state_d = ST_CMDRSP;
                end
            end
            ST_CMDRSP: begin
                if (pi1_rdy_i) begin
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_VERREQ;
            end
        endcase

        busy_d = (state_d != ST_DONE);
    end

    // Entry write, in the same edge that advances the entry counter.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            id_mem[wr_idx]   <= id_q;
            base_mem[wr_idx] <= base_q;
            sz_mem[wr_idx]   <= rsp_sz;
            irq_mem[wr_idx]  <= pi1_data_i[0];
        end
    end

    // Registered lookup; indices beyond the valid count read as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ent_id_q   <= '0;
            ent_base_q <= '0;
            ent_sz_q   <= '0;
            ent_irq_q  <= 1'b0;
        end else if (lk_hit) begin
            ent_id_q   <= id_mem[idx_i];
            ent_base_q <= base_mem[idx_i];
            ent_sz_q   <= sz_mem[idx_i];
            ent_irq_q  <= irq_mem[idx_i];
        end else begin
            ent_id_q   <= '0;
            ent_base_q <= '0;
            ent_sz_q   <= '0;
            ent_irq_q  <= 1'b0;
        end
    end

    assign pi1_op_o   = op_q;
    assign pi1_addr_o = addr_q;
    assign pi1_data_o = data_q;
    assign pi1_sel_o  = '1;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign version_o  = version_q;
    assign devcnt_o   = k_q;
    assign ent_id_o   = ent_id_q;
    assign ent_base_o = ent_base_q;
    assign ent_sz_o   = ent_sz_q;
    assign ent_irq_o  = ent_irq_q;
    assign cmd_ack_o  = ack_q;

endmodule

// File: tb/tb_devtbl_walker.sv
// Testbench for devtbl_walker: a PI1 responder backed by a device-table
// memory model, plus a reference model of the expected op stream and table.
module tb_devtbl_walker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  op;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic [3:0]  sel;
    logic        rdy = 1'b0;
    logic        busy, done;
    logic [31:0] version;
    logic [4:0]  devcnt;
    logic [3:0]  idx = '0;
    logic [31:0] ent_id;
    logic [29:0] ent_base, ent_sz;
    logic        ent_irq;
    logic        cmd_vld = 1'b0;
    logic [1:0]  cmd = '0;
    logic        cmd_ack;

    devtbl_walker dut (
        .clk_i(clk), .rst_i(rst_n),
        .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(wdata),
        .pi1_data_i(rdata), .pi1_sel_o(sel), .pi1_rdy_i(rdy),
        .busy_o(busy), .done_o(done), .version_o(version), .devcnt_o(devcnt),
        .idx_i(idx), .ent_id_o(ent_id), .ent_base_o(ent_base),
        .ent_sz_o(ent_sz), .ent_irq_o(ent_irq),
        .cmd_vld_i(cmd_vld), .cmd_i(cmd), .cmd_ack_o(cmd_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Device-table memory seen by the responder
    logic [31:0] m_id [40];
    logic [31:0] m_sw [40];
    logic [31:0] m_ver;

    // Accepted-op log
    logic [1:0]  lg_op[$];
    logic [29:0] lg_addr[$];
    logic [31:0] lg_data[$];
    logic [31:0] ver_at_rd;
    bit          ver_seen;

    bit          stall_mode = 0;
    int          stall = 0;
    bit          pend = 0;
    logic [31:0] resp;
    bit          prev_valid = 0;
    bit          prev_rdy;
    logic [63:0] prev_bus;

    function automatic logic [31:0] resp_of(input logic [1:0] o, input logic [29:0] a);
        int off;
        off = int'(a) - 'h80;
        if (o == 2'b11) return (off == 0) ? m_ver : 32'h0;
        if (off >= 0 && off < 80) return (off % 2 == 0) ? m_id[off/2] : m_sw[off/2];
        return 32'hBAD0BAD0;
    endfunction

    // Responder: decides rdy/data at each negedge for the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; stall = 0; rdy = 1'b0; prev_valid = 0;
        end else begin
            if (prev_valid && !prev_rdy && prev_bus[63:62] != 2'b00)
                chk("hold", {op, addr, wdata}, prev_bus);
            if (stall_mode) begin
                if ((pend || op != 2'b00) && stall < 3) begin rdy = 1'b0; stall++; end
                else begin rdy = 1'b1; stall = 0; end
            end else begin
                rdy = ($urandom % 3) != 0;
            end
            rdata = $urandom;
            if (rdy && pend) begin
                rdata = resp; pend = 0;
            end else if (rdy && op != 2'b00) begin
                lg_op.push_back(op); lg_addr.push_back(addr); lg_data.push_back(wdata);
                if (op == 2'b10 && addr == 30'h80 && !ver_seen) begin
                    ver_at_rd = version; ver_seen = 1;
                end
                resp = resp_of(op, addr);
                pend = 1;
            end
            prev_valid = 1; prev_rdy = rdy; prev_bus = {op, addr, wdata};
        end
    end

    // Reference model results
    logic [1:0]  ex_op[$];
    logic [29:0] ex_addr[$];
    logic [31:0] ex_data[$];
    logic [31:0] e_id [16];
    logic [29:0] e_base [16];
    logic [29:0] e_sz [16];
    logic        e_irq [16];
    int          e_n;

    task automatic build_expect;
        logic [29:0] base;
        ex_op.delete(); ex_addr.delete(); ex_data.delete();
        ex_op.push_back(2'b11); ex_addr.push_back(30'h80); ex_data.push_back(0);
        base = 0; e_n = 0;
        for (int k = 0; k < 16; k++) begin
            ex_op.push_back(2'b10); ex_addr.push_back(30'(32'h80 + 2*k)); ex_data.push_back(0);
            if (m_id[k] == 0) break;
            ex_op.push_back(2'b10); ex_addr.push_back(30'(32'h80 + 2*k + 1)); ex_data.push_back(0);
            e_id[k] = m_id[k];
            e_sz[k] = 30'(m_sw[k] / 4);
            e_irq[k] = m_sw[k][0];
            e_base[k] = base;
            base = base + e_sz[k];
            e_n++;
        end
    endtask

    task automatic clear_log;
        lg_op.delete(); lg_addr.delete(); lg_data.delete(); ver_seen = 0; ver_at_rd = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_op"}, {op, addr, wdata}, 64'h0);
        chk({tag, "_stat"}, {busy, done, devcnt, cmd_ack}, 64'h0);
        chk({tag, "_ver"}, version, 64'h0);
        chk({tag, "_ent"}, {ent_id, ent_irq}, 64'h0);
        chk({tag, "_entbs"}, {ent_base, ent_sz}, 64'h0);
    endtask

    task automatic do_reset;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        clear_log();
        rst_n = 1'b1;
    endtask

    task automatic scan_and_check(input string tag, input bit vld_during);
        int cyc;
        build_expect();
        if (vld_during) begin cmd_vld = 1'b1; cmd = 2'd2; end
        cyc = 0;
        while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
        cmd_vld = 1'b0;
        chk({tag, "_done_in_time"}, cyc < 5000, 1);
        repeat (20) @(negedge clk);
        chk({tag, "_busy_done"}, {busy, done}, 2'b01);
        chk({tag, "_devcnt"}, devcnt, e_n);
        chk({tag, "_version"}, version, m_ver);
        chk({tag, "_ver_before_rd"}, ver_at_rd, m_ver);
        chk({tag, "_nops"}, lg_op.size(), ex_op.size());
        for (int i = 0; i < lg_op.size() && i < ex_op.size(); i++) begin
            chk($sformatf("%s_op%0d", tag, i), {lg_op[i], lg_addr[i]}, {ex_op[i], ex_addr[i]});
            if (ex_op[i] == 2'b11) chk($sformatf("%s_opd%0d", tag, i), lg_data[i], ex_data[i]);
        end
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            @(negedge clk);
            if (i < e_n) begin
                chk($sformatf("%s_id%0d", tag, i), ent_id, e_id[i]);
                chk($sformatf("%s_bs%0d", tag, i), {ent_base, ent_sz, ent_irq}, {e_base[i], e_sz[i], e_irq[i]});
            end else begin
                chk($sformatf("%s_zero%0d", tag, i), {ent_id, ent_base, ent_sz, ent_irq}, 0);
            end
        end
    endtask

    task automatic load_directed;
        logic [31:0] ids [7];
        logic [31:0] sws [7];
        ids = '{4, 7, 2, 3, 5, 1, 0};
        sws = '{32'h201, 32'hDE0, 32'h11, 32'h8, 32'h9, 32'h40000, 32'h0};
        for (int i = 0; i < 40; i++) begin m_id[i] = 0; m_sw[i] = $urandom; end
        for (int i = 0; i < 7; i++) begin m_id[i] = ids[i]; m_sw[i] = sws[i]; end
        m_ver = 32'h00010203;
    endtask

    task automatic check_directed_consts;
        int unsigned bases [6];
        int unsigned sizes [6];
        bit irqs [6];
        bases = '{0, 128, 1016, 1020, 1022, 1024};
        sizes = '{128, 888, 4, 2, 2, 'h10000};
        irqs  = '{1, 0, 1, 0, 1, 0};
        chk("dir_devcnt6", devcnt, 6);
        for (int i = 0; i < 6; i++) begin
            idx = 4'(i);
            @(negedge clk);
            chk($sformatf("dir_const%0d", i), {ent_base, ent_sz, ent_irq}, {30'(bases[i]), 30'(sizes[i]), irqs[i]});
        end
    endtask

    initial begin
        int n0, acks, cyc;

        // Directed table, random rdy, command request held during the scan
        load_directed();
        stall_mode = 0;
        do_reset();
        scan_and_check("dir", 1);
        check_directed_consts();

        // Reset command after DONE
        @(negedge clk);
        n0 = lg_op.size();
        cmd = 2'd3; cmd_vld = 1'b1; acks = 0; cyc = 0;
        while (acks == 0 && cyc < 500) begin
            @(negedge clk); cyc++;
            if (cmd_ack) begin acks++; cmd_vld = 1'b0; end
        end
        cmd_vld = 1'b0;
        repeat (10) begin @(negedge clk); if (cmd_ack) acks++; end
        chk("cmd_acks", acks, 1);
        chk("cmd_nops", lg_op.size(), n0 + 1);
        if (lg_op.size() == n0 + 1)
            chk("cmd_op", {lg_op[n0], lg_addr[n0], lg_data[n0]}, {2'b11, 30'h81, 32'h3});
        chk("cmd_done_kept", {busy, done}, 2'b01);

        // Same table with 3-cycle stalls on every accept and response
        stall_mode = 1;
        do_reset();
        scan_and_check("stall", 0);

        // 20 entries: capped at MAXDEVS
        for (int i = 0; i < 40; i++) begin m_id[i] = (i < 20) ? i + 1 : 0; m_sw[i] = 32'h10; end
        m_ver = 32'hCAFE0001;
        stall_mode = 0;
        do_reset();
        scan_and_check("cap", 0);
        idx = 4'd15; @(negedge clk);
        chk("cap_lastbase", ent_base, 60);

        // Asynchronous reset while waiting for the size of entry 3
        load_directed();
        stall_mode = 1;
        do_reset();
        cyc = 0;
        while (lg_op.size() < 9 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("mid_reached", lg_op.size(), 9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clk); @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        scan_and_check("mid_rescan", 0);

        // Randomized tables
        stall_mode = 0;
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(0, 18);
            for (int i = 0; i < 40; i++) begin
                m_id[i] = 0; m_sw[i] = $urandom;
                if (i < n) begin m_id[i] = $urandom; if (m_id[i] == 0) m_id[i] = 1; end
            end
            m_ver = $urandom;
            do_reset();
            scan_and_check($sformatf("rnd%0d", r), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/devtbl_walker.md
Name: devtbl_walker

Overview:
- PI1 initiator that walks the device table from the other end of the bus.
- Out of reset it reads the SoC version (RWOP query 0), then reads id/size word pairs until it hits an id of 0 or MAXDEVS entries.
- Computes each device's base word address and stores id/base/size/irq-flag in a small indexed table.
- After the scan it can issue devtbl reset commands (RWOP to devtbl word 1) on behalf of a boot/debug controller.

Parameters:
ARCHBITSZ, 32, bus data width; ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8)
DEVTBLADDR, 'h0080, word address of devtbl word 0
FIRSTDEVADDR, 0, word address given to the first table entry
MAXDEVS, 16, table capacity (power of 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
pi1_op_o  out  2  00 NOOP, 01 WR, 10 RD, 11 RW
pi1_addr_o  out  ADDRBITSZ  word address
pi1_data_o  out  ARCHBITSZ  write/RW data
pi1_data_i  in  ARCHBITSZ  response data
pi1_sel_o  out  ARCHBITSZ/8  byte select, always all-ones
pi1_rdy_i  in  1  responder ready
busy_o  out  1  scan or command in progress
done_o  out  1  scan complete, sticky until reset
version_o  out  ARCHBITSZ  SoC version captured from RW query 0
devcnt_o  out  clog2(MAXDEVS)+1  number of valid entries
idx_i  in  clog2(MAXDEVS)  lookup index
ent_id_o  out  ARCHBITSZ  entry id at idx_i
ent_base_o  out  ADDRBITSZ  entry base word address
ent_sz_o  out  ADDRBITSZ  entry size in words
ent_irq_o  out  1  entry flag bit0
cmd_vld_i  in  1  reset-command request
cmd_i  in  2  value written to devtbl word 1 (0 rst0, 1 rst1, 2 both, 3 rst2)
cmd_ack_o  out  1  one-cycle pulse when command response is taken

Behaviour:
- Reset (rst_i=0, async): every output 0, state VERREQ, base accumulator = FIRSTDEVADDR, entry counter 0, table valid cleared.
- Handshake: an op is accepted on a rising edge with pi1_op_o!=NOOP and pi1_rdy_i=1.
- pi1_data_i is sampled on the first later edge with pi1_rdy_i=1.
- pi1_op_o is NOOP while waiting for the response.
- pi1_op_o/addr/data hold stable while pi1_rdy_i=0.
- FSM, each *REQ state drives one op, each *RSP state samples one response:
  - VERREQ: RW, addr DEVTBLADDR, data 0 -> VERRSP.
  - VERRSP: version_o <= data -> IDREQ.
  - IDREQ: RD addr DEVTBLADDR+2k -> IDRSP.
  - IDRSP: if data==0 go to DONE; else latch id -> SZREQ.
  - SZREQ: RD addr DEVTBLADDR+2k+1 -> SZRSP.
  - SZRSP: sz = data>>clog2(ARCHBITSZ/8), irq = data[0]. Write entry k {id, base, sz, irq}; base += sz (mod 2^ADDRBITSZ, wraps silently); k++. If k==MAXDEVS go to DONE, else IDREQ.
  - DONE: done_o=1, busy_o=0. cmd_vld_i -> CMDREQ, with cmd_i latched.
  - CMDREQ: RW addr DEVTBLADDR+1, data = zero-extended cmd -> CMDRSP.
  - CMDRSP: on response pulse cmd_ack_o -> DONE.
- cmd_vld_i is ignored outside DONE; the requester holds it until cmd_ack_o.
- A command of 1 or 2 may reset this block's own domain mid-op; async reset restarts the scan cleanly and no partial entry is kept.
- busy_o=1 in every state except DONE.
- devcnt_o = k, updated in the same edge as the entry write.
- Lookup: ent_* registered, 1-cycle latency from idx_i. idx_i >= devcnt_o returns all zeros.

Test Plan:
- Devtbl model with ARCHBITSZ=32, DEVTBLADDR='h80, FIRSTDEVADDR=0, table (4,'h201) (7,'hDE0) (2,'h11) (3,'h8) (5,'h9) (1,'h40000) (0) -> devcnt_o=6, done_o=1.
  - Bases 0, 128, 1016, 1020, 1022, 1024.
  - Sizes 128, 888, 4, 2, 2, 'h10000.
  - irq flags 1, 0, 1, 0, 1, 0.
- Same scan with version word 'h00010203 at RW query 0 -> version_o='h00010203, captured before the first RD to 'h80.
- pi1_rdy_i=0 for 3 cycles on every accept and every response -> op/addr held stable, identical final table, no duplicate ops.
- Table with 20 nonzero entries of size word 'h10 -> stops at devcnt_o=16, last base 60, no RD beyond addr 'h80+31.
- After DONE, cmd_vld_i=1, cmd_i=3 -> one RW op, addr 'h81, data 3; cmd_ack_o pulses once; cmd_vld_i during scan is ignored.
- rst_i low mid-SZRSP at entry 3 -> outputs 0 immediately; after release the scan restarts with RW query 0 and completes with the correct table.
